// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
// Executes MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU beside the EX-stage ALU.
// Multiply is shift-add and divide is restoring; each retires one bit per cycle,
// followed by a single sign-fix cycle.
//
// Ports:
//   i_clk       rising-edge clock
//   i_reset     synchronous active-high reset (aborts any operation in flight)
//   i_valid     instruction presented on i_op / i_alu_A / i_alu_B
//   i_op        funct code
//   i_alu_A     rs operand (dividend / multiplicand / MTxx source)
//   i_alu_B     rt operand (divisor / multiplier)
//   o_result    combinational HI (MFHI), LO (MFLO), else 0
//   o_hi, o_lo  architectural HI / LO registers
//   o_busy      iterative operation in flight
//   o_done      one-cycle pulse: HI/LO were just written by an operation
//   o_div_zero  one-cycle pulse with o_done when the divisor was zero
//   o_stall     i_valid & o_busy & i_op is one of the eight handled functs
module alu_muldiv #(
  parameter int N    = 32,
  parameter int NSel = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic [NSel-1:0] i_op,
  input  logic [N-1:0]    i_alu_A,
  input  logic [N-1:0]    i_alu_B,
  output logic [N-1:0]    o_result,
  output logic [N-1:0]    o_hi,
  output logic [N-1:0]    o_lo,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_div_zero,
  output logic            o_stall
);

  localparam int CW = $clog2(N + 1);

  localparam logic [NSel-1:0] F_MFHI  = NSel'(6'b010000);
  localparam logic [NSel-1:0] F_MTHI  = NSel'(6'b010001);
  localparam logic [NSel-1:0] F_MFLO  = NSel'(6'b010010);
  localparam logic [NSel-1:0] F_MTLO  = NSel'(6'b010011);
  localparam logic [NSel-1:0] F_MULT  = NSel'(6'b011000);
  localparam logic [NSel-1:0] F_MULTU = NSel'(6'b011001);
  localparam logic [NSel-1:0] F_DIV   = NSel'(6'b011010);
  localparam logic [NSel-1:0] F_DIVU  = NSel'(6'b011011);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // acc: upper product half / partial remainder.
  // mq : multiplier or dividend, shifting out as product low half / quotient shifts in.
  // b  : held operand magnitude (multiplicand for MUL, divisor for DIV).
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   mq_q, mq_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic           isdiv_q, isdiv_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  // Decode
  logic is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic is_mult, is_multu, is_div, is_divu;
  logic is_start, is_known;

  assign is_mfhi  = (i_op == F_MFHI);
  assign is_mthi  = (i_op == F_MTHI);
  assign is_mflo  = (i_op == F_MFLO);
  assign is_mtlo  = (i_op == F_MTLO);
  assign is_mult  = (i_op == F_MULT);
  assign is_multu = (i_op == F_MULTU);
  assign is_div   = (i_op == F_DIV);
  assign is_divu  = (i_op == F_DIVU);
  assign is_start = is_mult | is_multu | is_div | is_divu;
  assign is_known = is_start | is_mfhi | is_mthi | is_mflo | is_mtlo;

  // Operand magnitudes; unsigned ops never set a sign flag.
  logic         a_neg, b_neg;
  logic [N-1:0] a_mag, b_mag;

  assign a_neg = (is_mult | is_div) & i_alu_A[N-1];
  assign b_neg = (is_mult | is_div) & i_alu_B[N-1];
  assign a_mag = a_neg ? -i_alu_A : i_alu_A;
  assign b_mag = b_neg ? -i_alu_B : i_alu_B;

  // Datapath for one iteration
  logic [N:0]   sum;
  logic [N:0]   shifted;
  logic [N-1:0] diff;
  logic         ge;

  assign sum     = {1'b0, acc_q} + {1'b0, b_q & {N{mq_q[0]}}};
  assign shifted = {acc_q, mq_q[N-1]};
  // When ge holds the true difference is < divisor, so N bits suffice.
  assign diff    = shifted[N-1:0] - b_q;
  assign ge      = (shifted >= {1'b0, b_q});

  logic [2*N-1:0] prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    isdiv_d = isdiv_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    prod    = {acc_q, mq_q};

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (is_start) begin
            sa_d    = a_neg;
            sb_d    = b_neg;
            isdiv_d = is_div | is_divu;
            acc_d   = '0;
            cnt_d   = CW'(N);
            if (is_div | is_divu) begin
              mq_d    = a_mag;
              b_d     = b_mag;
              state_d = S_DIV;
            end else begin
              mq_d    = b_mag;
              b_d     = a_mag;
              state_d = S_MUL;
            end
          end else if (is_mthi) begin
            hi_d = i_alu_A;
          end else if (is_mtlo) begin
            lo_d = i_alu_A;
          end
        end
      end

      S_MUL: begin
        acc_d = sum[N:1];
        mq_d  = {sum[0], mq_q[N-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end

      S_DIV: begin
        acc_d = ge ? diff : shifted[N-1:0];
        mq_d  = {mq_q[N-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (isdiv_q) begin
          // With a zero divisor the remainder path leaves the dividend
          // magnitude in acc, so the usual remainder sign fix restores raw A.
          hi_d = sa_q ? -acc_q : acc_q;
          if (b_q == '0) begin
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            lo_d = (sa_q ^ sb_q) ? -mq_q : mq_q;
          end
        end else begin
          if (sa_q ^ sb_q) prod = -{acc_q, mq_q};
          hi_d = prod[2*N-1:N];
          lo_d = prod[N-1:0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      isdiv_q <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      isdiv_q <= isdiv_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = done_q;
  assign o_div_zero = dz_q;
  assign o_stall    = i_valid & o_busy & is_known;
  assign o_result   = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (N=32): the driver pushes the expected
// HI/LO/div-zero for each started operation; a monitor pops on every o_done.
module tb_alu_muldiv;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_OTHER = 6'b100000;

  logic        i_clk, i_reset, i_valid;
  logic [5:0]  i_op;
  logic [31:0] i_alu_A, i_alu_B;
  logic [31:0] o_result, o_hi, o_lo;
  logic        o_busy, o_done, o_div_zero, o_stall;

  alu_muldiv #(.N(32), .NSel(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_op(i_op),
    .i_alu_A(i_alu_A), .i_alu_B(i_alu_B), .o_result(o_result),
    .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done),
    .o_div_zero(o_div_zero), .o_stall(o_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward
  // zero with the remainder taking the dividend's sign, as MIPS does.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sb64, p, q, r;
    logic [63:0] up;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    e.hi = '0; e.lo = '0; e.dz = 1'b0;
    case (op)
      OP_MULT:  begin p = sa * sb64; e.hi = p[63:32]; e.lo = p[31:0]; end
      OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
      OP_DIV: begin
        if (b == 32'd0) begin e.lo = '1; e.hi = a; e.dz = 1'b1; end
        else begin q = sa / sb64; r = sa % sb64; e.lo = q[31:0]; e.hi = r[31:0]; end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin e.lo = '1; e.hi = a; e.dz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Called away from a clock edge; returns at posedge+1 of the accept edge.
  task automatic start_only(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    sb.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    i_valid = 1'b1; i_op = op; i_alu_A = a; i_alu_B = b;
    @(posedge i_clk); #1;
    chk("accept_busy", o_busy, 1);
    i_valid = 1'b0;
    i_alu_A = $urandom; i_alu_B = $urandom;
  endtask

  // Returns at posedge+1 of the o_done edge (or after the bound expires).
  task automatic wait_done(input int n0, input int b0);
    int n = n0;
    int bz = b0;
    while (!o_done && n < 100) begin
      @(posedge i_clk); #1;
      n++;
      if (o_busy) bz++;
    end
    chk("latency", n, 33);
    chk("busy_cycles", bz, 33);
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start_only(op, a, b);
    wait_done(0, 1);
  endtask

  // Monitor: compare HI/LO/div-zero against the scoreboard on every o_done.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (o_div_zero) chk("div_zero_with_done", o_done, 1);
      if (o_done) begin
        chk("done_single_pulse", prev_done, 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", o_done, 0);
        end else begin
          e = sb.pop_front();
          chk("HI", o_hi, e.hi);
          chk("LO", o_lo, e.lo);
          chk("div_zero", o_div_zero, e.dz);
        end
      end
      prev_done = o_done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_hi, old_lo;
    logic [5:0]  ops [4];
    logic [5:0]  busy_ops [3];
    logic [31:0] ra, rb;
    int          n, bz, dcount;

    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    busy_ops[0] = OP_MFLO; busy_ops[1] = OP_MTHI; busy_ops[2] = OP_MULT;

    i_reset = 1'b1; i_valid = 1'b0; i_op = OP_OTHER; i_alu_A = '0; i_alu_B = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_hi", o_hi, 0);
    chk("reset_lo", o_lo, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_div_zero", o_div_zero, 0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // Largest unsigned product; then read back HI/LO in the done cycle.
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    i_valid = 1'b1; i_op = OP_MFHI; #1;
    chk("mfhi_done_cycle", o_result, 32'hFFFF_FFFE);
    i_op = OP_MFLO; #1;
    chk("mflo_done_cycle", o_result, 32'h0000_0001);
    i_valid = 1'b0;
    @(negedge i_clk);

    // Signed multiply, then DIVU issued in the o_done cycle.
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    run_op(OP_DIVU, 32'd100, 32'd7);
    // Signed divide, overflow case, divide by zero.
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h1234_5678, 32'd0);
    run_op(OP_DIVU, 32'h8765_4321, 32'd0);
    run_op(OP_DIV, 32'h8765_4321, 32'd0);
    @(negedge i_clk);

    // Requests while busy must stall and have no effect.
    old_hi = model_hi;
    old_lo = model_lo;
    start_only(OP_MULT, 32'h0001_0003, 32'hFFFF_0005);
    n = 0; bz = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_valid = 1'b1; i_op = busy_ops[k]; i_alu_A = 32'h0000_00A5; i_alu_B = 32'd9;
      #1;
      chk("stall_while_busy", o_stall, 1);
      @(posedge i_clk); #1;
      n++;
      if (o_busy) bz++;
      chk("hi_held_busy", o_hi, old_hi);
      chk("lo_held_busy", o_lo, old_lo);
    end
    i_valid = 1'b0;
    wait_done(n, bz);

    // MTHI / MTLO then MFHI / MFLO; unknown funct yields 0 with no stall.
    i_valid = 1'b1; i_op = OP_MTHI; i_alu_A = 32'h0000_00A5;
    @(posedge i_clk); #1;
    model_hi = 32'h0000_00A5;
    i_op = OP_MFHI; #1;
    chk("mthi_mfhi", o_result, model_hi);
    i_op = OP_MTLO; i_alu_A = 32'h5A5A_0001;
    @(posedge i_clk); #1;
    model_lo = 32'h5A5A_0001;
    i_op = OP_MFLO; #1;
    chk("mtlo_mflo", o_result, model_lo);
    i_op = OP_OTHER; #1;
    chk("other_result", o_result, 0);
    chk("other_stall", o_stall, 0);
    @(posedge i_clk); #1;
    chk("other_no_hi_change", o_hi, model_hi);
    chk("other_no_lo_change", o_lo, model_lo);
    i_valid = 1'b0;
    @(negedge i_clk);

    // Randomised operations, issued back-to-back in each done cycle.
    for (int t = 0; t < 24; t++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: begin ra = $urandom_range(0, 1000); rb = -$urandom_range(1, 50); end
        default: ;
      endcase
      run_op(ops[$urandom_range(0, 3)], ra, rb);
    end
    @(negedge i_clk);

    // Reset on the 10th edge of a DIV aborts it silently.
    start_only(OP_DIV, 32'hDEAD_BEEF, 32'h0000_0013);
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    sb.delete();
    model_hi = '0;
    model_lo = '0;
    chk("abort_busy", o_busy, 0);
    chk("abort_hi", o_hi, 0);
    chk("abort_lo", o_lo, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_done) dcount++;
    end
    chk("no_done_after_abort", dcount, 0);

    // Unit recovers after the abort.
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
